// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Pure declarations: no logic, no latency, no flow control.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;
  localparam logic [31:0] DEF_TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0040_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: ROM port, execute redirect, decode handshake and fault report.
// master = fetch unit side; slave = ROM/execute/decode side.
interface instr_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_rd_i;
  logic                  redirect_i;
  logic [31:0]           redirect_pc_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [31:0]           pc_o;
  logic                  fault_o;
  logic [31:0]           fault_pc_o;

  modport master (
    output rom_addr_o, valid_o, instr_o, pc_o, fault_o, fault_pc_o,
    input  rom_rd_i, redirect_i, redirect_pc_i, ready_i
  );

  modport slave (
    input  rom_addr_o, valid_o, instr_o, pc_o, fault_o, fault_pc_o,
    output rom_rd_i, redirect_i, redirect_pc_i, ready_i
  );

endinterface

// File: rtl/fetch_window_chk.sv
// Combinational fetch-address check: word alignment and ROM window membership.
// Zero latency, no flow control; the window bound uses 33 bits so it cannot wrap.
module fetch_window_chk
  import riscv_fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE
) (
  input  logic [31:0] i_addr,
  output logic        o_misaligned,
  output logic        o_out_of_window
);

  localparam logic [32:0] WIN_LO = {1'b0, TEXT_BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << ADDR_WIDTH);

  logic [32:0] w_addr_ext;

  assign w_addr_ext      = {1'b0, i_addr};
  assign o_misaligned    = (i_addr[1:0] != 2'b00);
  assign o_out_of_window = (w_addr_ext < WIN_LO) || (w_addr_ext >= WIN_HI);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the ROM combinationally and registers IF/ID (1-cycle PC->valid).
// Holds instr/pc while decode stalls; redirect flushes with a 1-cycle bubble; faults halt until reset.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [31:0]           r_pc;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [31:0]           r_pc_out;
  logic                  r_fault;
  logic [31:0]           r_fault_pc;

  logic                  w_redir_misal;
  logic                  w_redir_oow;
  logic                  w_pc_misal;
  logic                  w_pc_oow;
  logic                  w_load;
  logic                  w_do_load;
  logic                  w_do_redirect;
  logic                  w_do_fault;
  logic [31:0]           w_fault_addr;
  logic [31:0]           w_pc_off;
  logic                  w_unused_off;

  fetch_window_chk #(.ADDR_WIDTH(ADDR_WIDTH), .TEXT_BASE(TEXT_BASE)) u_redir_chk (
    .i_addr          (bus.redirect_pc_i),
    .o_misaligned    (w_redir_misal),
    .o_out_of_window (w_redir_oow)
  );

  fetch_window_chk #(.ADDR_WIDTH(ADDR_WIDTH), .TEXT_BASE(TEXT_BASE)) u_pc_chk (
    .i_addr          (r_pc),
    .o_misaligned    (w_pc_misal),
    .o_out_of_window (w_pc_oow)
  );

  assign w_pc_off        = r_pc - TEXT_BASE;
  assign bus.rom_addr_o  = w_pc_off[ADDR_WIDTH+1:2];
  assign w_unused_off    = ^{w_pc_off[31:ADDR_WIDTH+2], w_pc_off[1:0]};
  assign w_load          = !r_valid || bus.ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= BOOT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     w_state_nxt = w_do_fault ? HALT : RUN;
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = BOOT;
    endcase
  end

  // Redirect outranks both load and stall; a bad redirect is itself the fault.
  always_comb begin
    w_do_load     = 1'b0;
    w_do_redirect = 1'b0;
    w_do_fault    = 1'b0;
    w_fault_addr  = 32'h0;
    if (r_state == RUN) begin
      if (bus.redirect_i) begin
        if (w_redir_misal || w_redir_oow) begin
          w_do_fault   = 1'b1;
          w_fault_addr = bus.redirect_pc_i;
        end else begin
          w_do_redirect = 1'b1;
        end
      end else if (w_load) begin
        if (w_pc_misal || w_pc_oow) begin
          w_do_fault   = 1'b1;
          w_fault_addr = r_pc;
        end else begin
          w_do_load = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc_out   <= 32'h0;
      r_fault    <= 1'b0;
      r_fault_pc <= 32'h0;
    end else if (w_do_fault) begin
      r_fault    <= 1'b1;
      r_fault_pc <= w_fault_addr;
      r_valid    <= 1'b0;
    end else if (w_do_redirect) begin
      r_valid <= 1'b0;
      r_pc    <= bus.redirect_pc_i;
    end else if (w_do_load) begin
      r_instr  <= bus.rom_rd_i;
      r_pc_out <= r_pc;
      r_valid  <= 1'b1;
      r_pc     <= r_pc + 32'd4;
    end
  end

  assign bus.valid_o    = r_valid;
  assign bus.instr_o    = r_instr;
  assign bus.pc_o       = r_pc_out;
  assign bus.fault_o    = r_fault;
  assign bus.fault_pc_o = r_fault_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot bubble, stall, redirect, faults and async reset.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] rom [0:1023];

  instr_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

  instr_fetch_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (10),
    .TEXT_BASE  (32'h0040_0000),
    .RESET_PC   (32'h0040_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_rd_i = rom[bus.rom_addr_o];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] boot_words [0:3];

  initial begin
    boot_words[0] = 32'h0050_0093;
    boot_words[1] = 32'h0010_0113;
    boot_words[2] = 32'h0020_81B3;
    boot_words[3] = 32'h0000_006F;
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA500_0000 | 32'(i);
    for (int i = 0; i < 4; i++) rom[i] = boot_words[i];

    rst               = 1'b1;
    bus.ready_i       = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid",    32'(bus.valid_o), 32'h0);
    chk("rst_pc",       bus.pc_o, 32'h0);
    chk("rst_instr",    bus.instr_o, 32'h0);
    chk("rst_fault",    32'(bus.fault_o), 32'h0);
    chk("rst_fault_pc", bus.fault_pc_o, 32'h0);
    chk("rst_rom_addr", 32'(bus.rom_addr_o), 32'h0);
    rst = 1'b0;

    // Boot bubble then streaming at one per cycle
    @(negedge clk);
    chk("boot_valid", 32'(bus.valid_o), 32'h0);
    chk("boot_rom_addr", 32'(bus.rom_addr_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stream_valid", 32'(bus.valid_o), 32'h1);
      chk("stream_pc", bus.pc_o, 32'h0040_0000 + 32'(4 * i));
      chk("stream_instr", bus.instr_o, boot_words[i]);
    end

    // Asynchronous reset mid-stream, away from any clock edge
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(bus.valid_o), 32'h0);
    chk("async_pc", bus.pc_o, 32'h0);
    chk("async_instr", bus.instr_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reboot_valid", 32'(bus.valid_o), 32'h0);
    @(negedge clk);
    chk("reboot_pc", bus.pc_o, 32'h0040_0000);

    // Backpressure at pc 0x00400004
    @(negedge clk);
    chk("pre_stall_pc", bus.pc_o, 32'h0040_0004);
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.valid_o), 32'h1);
      chk("stall_pc", bus.pc_o, 32'h0040_0004);
      chk("stall_instr", bus.instr_o, 32'h0010_0113);
      chk("stall_rom_addr", 32'(bus.rom_addr_o), 32'h2);
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk("post_stall_pc", bus.pc_o, 32'h0040_0008);
    chk("post_stall_instr", bus.instr_o, 32'h0020_81B3);

    // Redirect while stalled with a valid instruction held
    bus.ready_i       = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0040_0010;
    @(negedge clk);
    chk("redir_flush_valid", 32'(bus.valid_o), 32'h0);
    bus.redirect_i = 1'b0;
    bus.ready_i    = 1'b1;
    @(negedge clk);
    chk("redir_valid", 32'(bus.valid_o), 32'h1);
    chk("redir_pc", bus.pc_o, 32'h0040_0010);
    chk("redir_instr", bus.instr_o, 32'hA500_0004);
    chk("redir_fault", 32'(bus.fault_o), 32'h0);

    // Misaligned redirect halts; a later legal redirect is ignored
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0040_0006;
    @(negedge clk);
    chk("misal_fault", 32'(bus.fault_o), 32'h1);
    chk("misal_fault_pc", bus.fault_pc_o, 32'h0040_0006);
    chk("misal_valid", 32'(bus.valid_o), 32'h0);
    bus.redirect_pc_i = 32'h0040_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_valid", 32'(bus.valid_o), 32'h0);
      chk("halt_fault", 32'(bus.fault_o), 32'h1);
      chk("halt_fault_pc", bus.fault_pc_o, 32'h0040_0006);
      chk("halt_rom_addr", 32'(bus.rom_addr_o), 32'h5);
    end
    bus.redirect_i = 1'b0;

    // Sequential run off the end of the ROM window
    rst = 1'b1;
    @(negedge clk);
    chk("rst_clears_fault", 32'(bus.fault_o), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("end_start_pc", bus.pc_o, 32'h0040_0000);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0040_0FF0;
    @(negedge clk);
    chk("end_bubble", 32'(bus.valid_o), 32'h0);
    bus.redirect_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("end_valid", 32'(bus.valid_o), 32'h1);
      chk("end_pc", bus.pc_o, 32'h0040_0FF0 + 32'(4 * i));
      chk("end_instr", bus.instr_o, 32'hA500_03FC + 32'(i));
    end
    @(negedge clk);
    chk("oow_fault", 32'(bus.fault_o), 32'h1);
    chk("oow_fault_pc", bus.fault_pc_o, 32'h0040_1000);
    chk("oow_valid", 32'(bus.valid_o), 32'h0);

    // Redirect just below the window
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("low_start_pc", bus.pc_o, 32'h0040_0000);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h003F_FFFC;
    @(negedge clk);
    chk("low_fault", 32'(bus.fault_o), 32'h1);
    chk("low_fault_pc", bus.fault_pc_o, 32'h003F_FFFC);
    chk("low_valid", 32'(bus.valid_o), 32'h0);
    bus.redirect_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch stage of the RISC-V core. Owns the program counter.
- Drives the word address of the single-port instruction ROM and captures its combinational read data into an IF/ID output register.
- Hands instructions to decode through a valid/ready handshake.
- Accepts branch/jump redirects from execute and raises a sticky fault on misaligned or out-of-window fetch addresses.

Parameters:
- DATA_WIDTH, 32, instruction width in bits; must match ROM data width.
- ADDR_WIDTH, 10, ROM word-address width; ROM holds 2**ADDR_WIDTH words.
- TEXT_BASE, 32'h0040_0000, byte address mapped to ROM word 0.
- RESET_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_addr_o  out  ADDR_WIDTH  word address to instruction ROM.
- rom_rd_i  in  DATA_WIDTH  ROM read data; combinational from rom_addr_o, same cycle.
- redirect_i  in  1  execute requests PC change (taken branch/jump).
- redirect_pc_i  in  32  target byte address.
- valid_o  out  1  instr_o/pc_o hold a valid fetched instruction.
- ready_i  in  1  decode accepts this cycle.
- instr_o  out  DATA_WIDTH  fetched instruction.
- pc_o  out  32  byte address of instr_o.
- fault_o  out  1  sticky fetch fault.
- fault_pc_o  out  32  offending address.

Behaviour:
- Reset (async, rst=1), all applied immediately:
  - pc_q=RESET_PC, valid_o=0, instr_o=0, pc_o=0, fault_o=0, fault_pc_o=0, state=BOOT.
  - Asserting reset mid-operation discards any held instruction.
- ROM address: rom_addr_o = (pc_q - TEXT_BASE) >> 2, truncated to ADDR_WIDTH bits. Driven in every state; reads are side-effect free.
- Window check: address is in-window iff TEXT_BASE <= addr < TEXT_BASE + 4*2**ADDR_WIDTH, using a 33-bit compare with no wrap.
- States: BOOT, RUN, HALT.
- BOOT:
  - Exactly one bubble cycle after reset release.
  - valid_o stays 0 and the PC is not advanced. Next state is RUN.
- RUN, load condition: load = !valid_o || ready_i.
  - When load is true: instr_o<=rom_rd_i, pc_o<=pc_q, valid_o<=1, pc_q<=pc_q+4 (32-bit wrap; the window check catches overflow).
  - When load is false (stall): pc_q, instr_o, pc_o and valid_o hold.
  - Throughput is one instruction per cycle while ready_i=1. Latency from PC to valid_o is one cycle.
- Redirect in RUN (priority over load and stall):
  - valid_o<=0 flushes the held instruction even if ready_i=1 that cycle; the handshake does not complete.
  - pc_q<=redirect_pc_i.
  - The first instruction from the target appears one cycle later (1-cycle redirect bubble).
- Fault:
  - Fault condition, evaluated in RUN, is either:
    - redirect_i=1 with redirect_pc_i[1:0]!=0, or redirect_pc_i out of window; or
    - a load attempted while pc_q is out of window (e.g. sequential run off the ROM end).
  - Action: fault_o<=1, fault_pc_o<=offending address, valid_o<=0, state<=HALT.
  - A fault detected on a load suppresses that load.
- HALT:
  - valid_o=0, pc_q frozen, redirect_i ignored.
  - Exit only via reset. fault_o stays 1.
- Simultaneous redirect and stall (ready_i=0, valid_o=1): the redirect wins and the stalled instruction is dropped.
- Outputs are registered, except rom_addr_o, which is combinational from pc_q.

Decomposition:
- Shared package riscv_fetch_pkg:
  - fetch_state_t enum {BOOT, RUN, HALT};
  - INSTR_NOP = 32'h0000_0013;
  - default TEXT_BASE/RESET_PC constants.
- Sub-module fetch_window_chk (combinational address alignment/range check, instantiated twice: for redirect_pc_i and for pc_q).
- Everything else lives in instr_fetch_unit.

Test Plan:
- Reset release with ready_i=1, ROM words 0..3 = 0x00500093, 0x00100113, 0x002081B3, 0x0000006F:
  - valid_o=0 on the first cycle after release (BOOT).
  - Then one instruction per cycle in order, pc_o=0x00400000, 0x00400004, 0x00400008, 0x0040000C.
- Backpressure: hold ready_i=0 for 3 cycles while pc_o=0x00400004 → instr_o=0x00100113 and pc_o stable, and rom_addr_o stays 2. After release, the next pc_o is 0x00400008.
- Redirect to 0x00400010 while valid_o=1, ready_i=0:
  - Next cycle valid_o=0.
  - Following cycle pc_o=0x00400010 with instr_o = ROM word 4.
- Misaligned redirect 0x00400006 → fault_o=1, fault_pc_o=0x00400006, valid_o=0 forever. A later redirect to 0x00400000 is ignored.
- Sequential fetch reaching 0x00401000 with ADDR_WIDTH=10:
  - The last valid pc_o is 0x00400FFC.
  - Then fault_o=1 with fault_pc_o=0x00401000.
- Reset asserted mid-stream (valid_o=1) → valid_o, pc_o and instr_o clear in the same cycle without a clock edge. Fetch restarts at RESET_PC after one BOOT bubble.
